seven_seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display.
- Holds a 16-bit hex value, a per-digit decimal-point mask and a per-digit enable mask.
- Steps through the digits, driving one anode at a time with that digit's segment pattern.
- Inserts a blanking interval between digits to suppress ghosting.
- Applies new display data only at frame boundaries, so a frame never shows a mix of old and new digits.
- Sits between user logic and the board's shared CA..CG/DP/AN pins.

---
 rtl/seven_seg_pkg.sv | 10 +
 rtl/seven_seg_hex_decode.sv | 9 +
 rtl/seven_seg_scan_ctrl.sv | 104 ++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared types and constants for the seven-segment scan controller.
package seven_seg_pkg;
   typedef enum logic {ST_BLANK = 1'b0, ST_ON = 1'b1} state_t;
   localparam int NUM_DIGITS = 4;
   // Active-low segment patterns, bit order {G,F,E,D,C,B,A}
   localparam logic [6:0] SEG_LUT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };
endpackage

// File: rtl/seven_seg_hex_decode.sv
// seven_seg_hex_decode: combinational hex nibble to active-low segment pattern.
module seven_seg_hex_decode
   import seven_seg_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);
   assign seg_o = SEG_LUT[hex_i];
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: 4-digit common-anode scan controller with blanking and
// frame-synchronous data update.
module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int PRESCALE  = 50000,
   parameter int BLANK_CYC = 500
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] DATA,
   input  logic [3:0]  DP_IN,
   input  logic [3:0]  EN_MASK,
   input  logic        LOAD,
   output logic        CA,
   output logic        CB,
   output logic        CC,
   output logic        CD,
   output logic        CE,
   output logic        CF,
   output logic        CG,
   output logic        DP,
   output logic [3:0]  AN,
   output logic        FRAME_DONE,
   output logic        PENDING
);
   localparam int CW = $clog2(PRESCALE);
   localparam state_t ST_RST = (BLANK_CYC == 0) ? ST_ON : ST_BLANK;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   state_t        state_q, state_d;
   logic [15:0]   val_q, stg_val_q;
   logic [3:0]    dp_q, stg_dp_q, msk_q, stg_msk_q;
   logic          pend_q;
   logic [3:0]    an_q;
   logic [6:0]    seg_q, hex_seg;
   logic          dp_out_q, fd_q;
   logic          slot_end, frame_end;
   logic [3:0]    nib;

   always_comb begin
      slot_end  = cnt_q == CW'(PRESCALE - 1);
      frame_end = slot_end && idx_q == 2'(NUM_DIGITS - 1);
      cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
      idx_d     = slot_end ? idx_q + 2'd1 : idx_q;
      state_d   = (int'(cnt_d) < BLANK_CYC) ? ST_BLANK : ST_ON;
      nib       = val_q[4*idx_q +: 4];
   end

   seven_seg_hex_decode u_dec (
      .hex_i (nib),
      .seg_o (hex_seg)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q     <= '0;
         idx_q     <= '0;
         state_q   <= ST_RST;
         val_q     <= '0;
         dp_q      <= '0;
         msk_q     <= '0;
         stg_val_q <= '0;
         stg_dp_q  <= '0;
         stg_msk_q <= '0;
         pend_q    <= 1'b0;
         an_q      <= 4'hF;
         seg_q     <= 7'h7F;
         dp_out_q  <= 1'b1;
         fd_q      <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         state_q  <= state_d;
         an_q     <= (state_q == ST_ON && msk_q[idx_q]) ? ~(4'b0001 << idx_q) : 4'hF;
         // Disabled digits keep their segments dark so a cleared display stays blank
         seg_q    <= msk_q[idx_q] ? hex_seg : 7'h7F;
         dp_out_q <= ~dp_q[idx_q];
         fd_q     <= frame_end;
         if (LOAD) begin
            stg_val_q <= DATA;
            stg_dp_q  <= DP_IN;
            stg_msk_q <= EN_MASK;
         end
         if (frame_end && LOAD) begin
            val_q <= DATA;
            dp_q  <= DP_IN;
            msk_q <= EN_MASK;
         end else if (frame_end && pend_q) begin
            val_q <= stg_val_q;
            dp_q  <= stg_dp_q;
            msk_q <= stg_msk_q;
         end
         pend_q <= frame_end ? 1'b0 : (pend_q || LOAD);
      end
   end

   assign {CG, CF, CE, CD, CC, CB, CA} = seg_q;
   assign DP         = dp_out_q;
   assign AN         = an_q;
   assign FRAME_DONE = fd_q;
   assign PENDING    = pend_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: randomized check of two builds (BLANK_CYC=2 and 0)
// against a slot-arithmetic reference model.
module tb_seven_seg_scan_ctrl;
   localparam int P = 8;
   localparam int B = 2;

   logic        CLK = 1'b0;
   logic        RST, LOAD;
   logic [15:0] DATA;
   logic [3:0]  DP_IN, EN_MASK;
   logic [6:0]  seg2, seg0;
   logic [3:0]  an2, an0;
   logic        dp2, dp0, fd2, fd0, pd2, pd0;

   seven_seg_scan_ctrl #(.PRESCALE(P), .BLANK_CYC(B)) u_dut (
      .CLK(CLK), .RST(RST), .DATA(DATA), .DP_IN(DP_IN), .EN_MASK(EN_MASK), .LOAD(LOAD),
      .CA(seg2[0]), .CB(seg2[1]), .CC(seg2[2]), .CD(seg2[3]), .CE(seg2[4]), .CF(seg2[5]),
      .CG(seg2[6]), .DP(dp2), .AN(an2), .FRAME_DONE(fd2), .PENDING(pd2)
   );

   seven_seg_scan_ctrl #(.PRESCALE(P), .BLANK_CYC(0)) u_dut0 (
      .CLK(CLK), .RST(RST), .DATA(DATA), .DP_IN(DP_IN), .EN_MASK(EN_MASK), .LOAD(LOAD),
      .CA(seg0[0]), .CB(seg0[1]), .CC(seg0[2]), .CD(seg0[3]), .CE(seg0[4]), .CF(seg0[5]),
      .CG(seg0[6]), .DP(dp0), .AN(an0), .FRAME_DONE(fd0), .PENDING(pd0)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_err = 0;

   string GLYPHS [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

   int          m_n;
   logic [15:0] sh_v, st_v;
   logic [3:0]  sh_dp, sh_m, st_dp, st_m;
   logic        m_pend;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] glyph(input logic [3:0] h);
      string s = GLYPHS[h];
      logic [6:0] r = 7'h7F;
      for (int i = 0; i < s.len(); i++) r[s[i] - 8'd97] = 1'b0;
      return r;
   endfunction

   function automatic int cur_pos();
      return m_n % P;
   endfunction

   function automatic int cur_dig();
      return (m_n / P) % 4;
   endfunction

   task automatic step(input logic rst, input logic ld, input logic [15:0] d,
                       input logic [3:0] dp, input logic [3:0] m);
      int pos, dig;
      logic bnd, lit;
      logic [3:0] ea2, ea0;
      logic [6:0] es;
      logic ed, efd;
      RST = rst; LOAD = ld; DATA = d; DP_IN = dp; EN_MASK = m;
      pos = cur_pos();
      dig = cur_dig();
      bnd = (pos == P - 1) && (dig == 3);
      if (rst) begin
         ea2 = 4'hF; ea0 = 4'hF; es = 7'h7F; ed = 1'b1; efd = 1'b0;
         m_n = 0; sh_v = '0; st_v = '0; sh_dp = '0; st_dp = '0; sh_m = '0; st_m = '0;
         m_pend = 1'b0;
      end else begin
         lit = sh_m[dig];
         ea0 = lit ? ~(4'd1 << dig) : 4'hF;
         ea2 = (lit && pos >= B) ? ~(4'd1 << dig) : 4'hF;
         es  = lit ? glyph(4'((sh_v >> (4 * dig)) & 16'hF)) : 7'h7F;
         ed  = ~sh_dp[dig];
         efd = bnd;
         if (bnd && ld) begin
            sh_v = d; sh_dp = dp; sh_m = m;
         end else if (bnd && m_pend) begin
            sh_v = st_v; sh_dp = st_dp; sh_m = st_m;
         end
         if (ld) begin
            st_v = d; st_dp = dp; st_m = m;
         end
         m_pend = bnd ? 1'b0 : (m_pend || ld);
         m_n++;
      end
      @(posedge CLK);
      #1;
      check("an_b2", {12'd0, an2}, {12'd0, ea2});
      check("seg_b2", {9'd0, seg2}, {9'd0, es});
      check("dp_b2", {15'd0, dp2}, {15'd0, ed});
      check("fd_b2", {15'd0, fd2}, {15'd0, efd});
      check("pend_b2", {15'd0, pd2}, {15'd0, m_pend});
      check("an_b0", {12'd0, an0}, {12'd0, ea0});
      check("seg_b0", {9'd0, seg0}, {9'd0, es});
      check("dp_b0", {15'd0, dp0}, {15'd0, ed});
      check("fd_b0", {15'd0, fd0}, {15'd0, efd});
      check("pend_b0", {15'd0, pd0}, {15'd0, m_pend});
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++)
         step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
   endtask

   task automatic to_boundary();
      for (int i = 0; i < 4 * P && !(cur_pos() == P - 1 && cur_dig() == 3); i++) idle(1);
   endtask

   initial begin
      m_n = 0;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'hFFFF, 4'hF, 4'hF);
      idle(40);
      step(1'b0, 1'b1, 16'h12AF, 4'b0100, 4'b1111);
      idle(80);
      idle(5);
      step(1'b0, 1'b1, 16'h1111, 4'b0000, 4'b1111);
      idle(3);
      step(1'b0, 1'b1, 16'h2222, 4'b0001, 4'b1111);
      idle(40);
      to_boundary();
      step(1'b0, 1'b1, 16'h3C5D, 4'b1000, 4'b1111);
      idle(35);
      step(1'b0, 1'b1, 16'hBE69, 4'b0011, 4'b0101);
      idle(70);
      step(1'b0, 1'b1, 16'h4780, 4'b1111, 4'b1111);
      idle(40);
      for (int i = 0; i < 4 * P && !(cur_dig() == 2 && cur_pos() == 4); i++) idle(1);
      step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
      idle(40);
      for (int i = 0; i < 2500; i++) begin
         logic rst, ld;
         rst = $urandom_range(0, 399) == 0;
         ld  = ($urandom_range(0, 19) == 0) ||
               (cur_pos() == P - 1 && cur_dig() == 3 && $urandom_range(0, 2) == 0);
         step(rst, ld, 16'($urandom), 4'($urandom), 4'($urandom));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
